// File: rtl/huffman_bit_serializer.sv
// huffman_bit_serializer
//   Takes one signed 4-bit sample per valid/ready handshake, looks up its
//   prefix-free Huffman code and emits it MSB-first, one bit per clock, on
//   out_bit/out_load. After each codeword, GAP_CYCLES idle cycles follow.
//   All outputs decode registered state, so they are glitch-free and reset
//   to their idle values one cycle after reset.
module huffman_bit_serializer #(
   parameter int unsigned MAX_CODE   = 9,   // longest codeword; must be >= 9
   parameter int unsigned GAP_CYCLES = 1    // idle cycles after each codeword, 0..15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sym_valid,
   input  logic [3:0] sym_in,
   output logic       sym_ready,
   output logic       out_bit,
   output logic       out_load,
   output logic       code_done,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [MAX_CODE-1:0] shreg_q, shreg_d;   // codeword, left-aligned; MSB is the bit on the wire
   logic [3:0]          cnt_q,   cnt_d;     // bits remaining, including the one being presented
   logic [3:0]          gap_q,   gap_d;     // idle cycles remaining in GAP

   logic [8:0]          lut_code;           // right-aligned codeword
   logic [3:0]          lut_len;
   logic [8:0]          code_left;
   logic [MAX_CODE-1:0] code_ext;

   // Codebook lookup: sample -> right-aligned code and its length.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      lut_code = 9'd0;
      lut_len  = 4'd1;
      case (sym_in)
         4'h8:    begin lut_code = 9'b111110010; lut_len = 4'd9; end  // -8
         4'h9:    begin lut_code = 9'b011111000; lut_len = 4'd8; end  // -7
         4'hA:    begin lut_code = 9'b001011000; lut_len = 4'd7; end  // -6
         4'hB:    begin lut_code = 9'b000101101; lut_len = 4'd6; end  // -5
         4'hC:    begin lut_code = 9'b000010111; lut_len = 4'd5; end  // -4
         4'hD:    begin lut_code = 9'b000001010; lut_len = 4'd4; end  // -3
         4'hE:    begin lut_code = 9'b000001101; lut_len = 4'd4; end  // -2
         4'hF:    begin lut_code = 9'b000001110; lut_len = 4'd4; end  // -1
         4'h0:    begin lut_code = 9'b000000000; lut_len = 4'd1; end  //  0
         4'h1:    begin lut_code = 9'b000000100; lut_len = 4'd3; end  //  1
         4'h2:    begin lut_code = 9'b000001100; lut_len = 4'd4; end  //  2
         4'h3:    begin lut_code = 9'b000011110; lut_len = 4'd5; end  //  3
         4'h4:    begin lut_code = 9'b000111111; lut_len = 4'd6; end  //  4
         4'h5:    begin lut_code = 9'b001111101; lut_len = 4'd7; end  //  5
         4'h6:    begin lut_code = 9'b001011001; lut_len = 4'd7; end  //  6
         4'h7:    begin lut_code = 9'b111110011; lut_len = 4'd9; end  //  7
         default: begin lut_code = 9'd0;         lut_len = 4'd1; end
      endcase
   end

   // Left-align the code so the shift register always emits from its MSB.
   always_comb begin
      code_left = lut_code << (4'd9 - lut_len);
      code_ext  = MAX_CODE'(code_left) << (MAX_CODE - 9);
   end

   // Next-state logic: accept in IDLE, shift one bit per cycle, then idle out the gap.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            if (sym_valid) begin
               shreg_d = code_ext;
               cnt_d   = lut_len;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == 4'd1) begin
               shreg_d = '0;
               cnt_d   = 4'd0;
               if (GAP_CYCLES > 0) begin
                  gap_d   = 4'(GAP_CYCLES);
                  state_d = GAP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               shreg_d = shreg_q << 1;
               cnt_d   = cnt_q - 4'd1;
            end
         end
         GAP: begin
            if (gap_q <= 4'd1) begin
               gap_d   = 4'd0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = 4'd0;
            gap_d   = 4'd0;
         end
      endcase
   end

   // State registers with synchronous reset; an in-flight codeword is simply dropped.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= 4'd0;
         gap_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

   // Output decode from registered state.
   always_comb begin
      sym_ready = (state_q == IDLE);
      busy      = (state_q == SHIFT) || (state_q == GAP);
      out_load  = (state_q == SHIFT);
      out_bit   = (state_q == SHIFT) && shreg_q[MAX_CODE-1];
      code_done = (state_q == SHIFT) && (cnt_q == 4'd1);
   end

endmodule
